// File: rtl/mem_access_stage_if.sv
// Doubleword memory bus between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: passes ALU results through, runs one load/store at a time on a
// request/ack bus with a 255-cycle timeout, and extracts/extends load data for writeback.
module mem_access_stage (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_in,
  input  logic [63:0]                 aluResult_in,
  input  logic [63:0]                 storeData_in,
  input  logic [4:0]                  rd_in,
  input  logic [2:0]                  funct3_in,
  input  logic                        MemRead_in,
  input  logic                        MemWrite_in,
  input  logic                        MemtoReg_in,
  input  logic                        RegWrite_in,
  mem_access_stage_if.master          bus,
  output logic [63:0]                 aluResult_out,
  output logic [63:0]                 memData_out,
  output logic [4:0]                  rd_out,
  output logic                        MemtoReg_out,
  output logic                        RegWrite_out,
  output logic                        stall,
  output logic                        misalign,
  output logic                        bus_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_q,  state_d;
  logic [7:0]  cnt_q,    cnt_d;
  logic [63:0] addr_q,   addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q,     rd_d;
  logic        m2r_q,    m2r_d;
  logic        rw_q,     rw_d;
  logic        store_q,  store_d;
  logic        err_q,    err_d;
  logic [63:0] wdata_q,  wdata_d;
  logic [7:0]  wstrb_q,  wstrb_d;
  logic [63:0] rdata_q,  rdata_d;

  logic        mem_op;
  logic        misaligned;
  logic [7:0]  size_mask;
  logic [63:0] lane;
  logic [63:0] load_data;

  assign mem_op = valid_in & (MemRead_in | MemWrite_in);

  // Access size comes from funct3[1:0] for both loads and stores (111 behaves as LD).
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first, otherwise a latch is inferred.
    size_mask  = 8'h01;
    misaligned = 1'b0;
    case (funct3_in[1:0])
      2'd0: begin size_mask = 8'h01; misaligned = 1'b0;                end
      2'd1: begin size_mask = 8'h03; misaligned = aluResult_in[0];     end
      2'd2: begin size_mask = 8'h0F; misaligned = |aluResult_in[1:0];  end
      default: begin size_mask = 8'hFF; misaligned = |aluResult_in[2:0]; end
    endcase
  end

  always_comb begin
    lane      = rdata_q >> {addr_q[2:0], 3'b000};
    load_data = lane;
    case (funct3_q)
      3'b000:  load_data = {{56{lane[7]}},  lane[7:0]};
      3'b001:  load_data = {{48{lane[15]}}, lane[15:0]};
      3'b010:  load_data = {{32{lane[31]}}, lane[31:0]};
      3'b100:  load_data = {56'd0, lane[7:0]};
      3'b101:  load_data = {48'd0, lane[15:0]};
      3'b110:  load_data = {32'd0, lane[31:0]};
      default: load_data = lane;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    m2r_d    = m2r_q;
    rw_d     = rw_q;
    store_d  = store_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_op && !misaligned) begin
          state_d  = BUSY;
          cnt_d    = 8'd0;
          addr_d   = aluResult_in;
          funct3_d = funct3_in;
          rd_d     = rd_in;
          m2r_d    = MemtoReg_in;
          rw_d     = RegWrite_in;
          store_d  = MemWrite_in;
          err_d    = 1'b0;
          rdata_d  = 64'd0;
          wdata_d  = MemWrite_in ? (storeData_in << {aluResult_in[2:0], 3'b000}) : 64'd0;
          wstrb_d  = MemWrite_in ? (size_mask << aluResult_in[2:0]) : 8'h00;
        end
      end
      BUSY: begin
        // An ack in the cycle the counter would hit 255 still completes normally.
        if (bus.mem_ack) begin
          rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else if (cnt_q == 8'd254) begin
          cnt_d   = 8'd255;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    aluResult_out  = aluResult_in;
    rd_out         = rd_in;
    MemtoReg_out   = MemtoReg_in;
    RegWrite_out   = RegWrite_in & valid_in;
    memData_out    = 64'd0;
    stall          = 1'b0;
    misalign       = 1'b0;
    bus_err        = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = 64'd0;
    bus.mem_wdata  = 64'd0;
    bus.mem_wstrb  = 8'h00;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          RegWrite_out = 1'b0;
          misalign     = misaligned;
          stall        = ~misaligned;
        end
      end
      BUSY: begin
        aluResult_out = addr_q;
        rd_out        = rd_q;
        MemtoReg_out  = m2r_q;
        RegWrite_out  = 1'b0;
        stall         = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = store_q;
        bus.mem_addr  = {addr_q[63:3], 3'b000};
        bus.mem_wdata = wdata_q;
        bus.mem_wstrb = wstrb_q;
      end
      RESP: begin
        aluResult_out = addr_q;
        rd_out        = rd_q;
        MemtoReg_out  = m2r_q;
        RegWrite_out  = rw_q & ~store_q & ~err_q;
        memData_out   = (store_q || err_q) ? 64'd0 : load_data;
        bus_err       = err_q;
      end
      default: ;
    endcase
    // Reset must quiet the status outputs at once, even while EX still presents a request.
    if (reset) begin
      stall        = 1'b0;
      misalign     = 1'b0;
      RegWrite_out = 1'b0;
    end
  end

  // NOTE: every state register, including the captured data words, is reset so no X ever reaches the bus or writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= 64'd0;
      funct3_q <= 3'd0;
      rd_q     <= 5'd0;
      m2r_q    <= 1'b0;
      rw_q     <= 1'b0;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= 64'd0;
      wstrb_q  <= 8'h00;
      rdata_q  <= 64'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      m2r_q    <= m2r_d;
      rw_q     <= rw_d;
      store_q  <= store_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
